id_ex_pipe_reg: RTL and testbench

ID/EX pipeline register for the pipelined MIPS datapath. It captures the decode-stage outputs (register-file read data, the 32-bit immediate from the sign/zero-extension unit, register specifiers and the control word) and presents them to the execute stage one cycle later. It owns load-use hazard detection, bubble insertion, flush and hold, and a saturating bubble counter.

---
 rtl/pipe_pkg.sv | 42 ++++
 rtl/load_use_detect.sv | 16 +
 rtl/id_ex_pipe_reg.sv | 111 +++++++++++
 tb/tb_id_ex_pipe_reg.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and control-word layout for the MIPS ID/EX pipeline register.
package pipe_pkg;

  localparam int CTRL_W = 10;

  // Bit positions inside the decoded control word.
  localparam int REG_WRITE  = 0;
  localparam int MEM_READ   = 1;
  localparam int MEM_WRITE  = 2;
  localparam int MEM_TO_REG = 3;
  localparam int ALU_SRC    = 4;
  localparam int REG_DST    = 5;
  localparam int ALU_OP     = 6;
  localparam int ALU_OP_W   = 3;
  localparam int ZERO_EXT   = 9;

  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

  // What the EX register does on the coming edge, in priority order.
  typedef enum logic [2:0] {
    UPD_RESET,
    UPD_FLUSH,
    UPD_HOLD,
    UPD_BUBBLE,
    UPD_LOAD
  } upd_e;

  typedef struct packed {
    logic              valid;
    logic [31:0]       pc4;
    logic [31:0]       rs_data;
    logic [31:0]       rt_data;
    logic [31:0]       imm;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [CTRL_W-1:0] ctrl;
  } idex_t;

  localparam idex_t IDEX_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use detector: a load in EX whose destination is read by ID.
module load_use_detect (
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       hazard
);

  // $zero never carries a dependency, even when a load names it.
  assign hazard = id_valid & ex_valid & ex_mem_read & (ex_rt != 5'd0) &
                  ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with flush, hold, bubble insertion and a saturating bubble counter.
// Define HAZARD_DETECT_EN to build in load-use detection; otherwise hazard_stall is tied low.
module id_ex_pipe_reg
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              id_valid,
  input  logic [31:0]       id_pc4,
  input  logic [31:0]       id_rs_data,
  input  logic [31:0]       id_rt_data,
  input  logic [31:0]       id_imm,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic              ex_valid,
  output logic [31:0]       ex_pc4,
  output logic [31:0]       ex_rs_data,
  output logic [31:0]       ex_rt_data,
  output logic [31:0]       ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              hazard_stall,
  output logic [CNT_W-1:0]  bubble_cnt
);

  idex_t ex_q;
  idex_t ex_d;
  idex_t id_in;
  upd_e  upd;
  logic  bump;

`ifdef HAZARD_DETECT_EN
  logic hazard_raw;

  load_use_detect u_load_use_detect (
    .ex_valid    (ex_q.valid),
    .ex_mem_read (ex_q.ctrl[MEM_READ]),
    .ex_rt       (ex_q.rt),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .hazard      (hazard_raw)
  );

  // A redirect discards the ID instruction, so there is nothing to hold upstream.
  assign hazard_stall = hazard_raw & ~Flush;
`else
  assign hazard_stall = 1'b0;
`endif

  // An invalid ID slot still passes its data through but never its control.
  assign id_in = '{
    valid:   id_valid,
    pc4:     id_pc4,
    rs_data: id_rs_data,
    rt_data: id_rt_data,
    imm:     id_imm,
    rs:      id_rs,
    rt:      id_rt,
    rd:      id_rd,
    ctrl:    id_valid ? id_ctrl : CTRL_NOP
  };

  always_comb begin
    // NOTE: default assigned first so every path drives upd and no latch is inferred.
    upd = UPD_LOAD;
    if (!Rst_n)            upd = UPD_RESET;
    else if (Flush)        upd = UPD_FLUSH;
    else if (Stall)        upd = UPD_HOLD;
    else if (hazard_stall) upd = UPD_BUBBLE;
  end

  always_comb begin
    ex_d = id_in;
    unique case (upd)
      UPD_RESET, UPD_FLUSH, UPD_BUBBLE: ex_d = IDEX_BUBBLE;
      UPD_HOLD:                         ex_d = ex_q;
      default:                          ex_d = id_in;
    endcase
  end

  assign bump = (upd == UPD_FLUSH) || (upd == UPD_BUBBLE);

  always_ff @(posedge Clk) begin
    // NOTE: non-blocking so every field and the counter update from pre-edge values.
    ex_q <= ex_d;
    if (!Rst_n)
      bubble_cnt <= '0;
    else if (bump && (bubble_cnt != '1))
      bubble_cnt <= bubble_cnt + CNT_W'(1);
  end

  assign ex_valid   = ex_q.valid;
  assign ex_pc4     = ex_q.pc4;
  assign ex_rs_data = ex_q.rs_data;
  assign ex_rt_data = ex_q.rt_data;
  assign ex_imm     = ex_q.imm;
  assign ex_rs      = ex_q.rs;
  assign ex_rt      = ex_q.rt;
  assign ex_rd      = ex_q.rd;
  assign ex_ctrl    = ex_q.ctrl;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: vector table, directed hazard sequences,
// randomized traffic against a behavioural model, and counter saturation.
module tb_id_ex_pipe_reg;
  import pipe_pkg::*;

`ifdef HAZARD_DETECT_EN
  localparam bit HAZ_EN = 1'b1;
`else
  localparam bit HAZ_EN = 1'b0;
`endif

  localparam int CNT_W   = 16;
  localparam int CNT_MAX = 65535;

  logic              Clk = 1'b0;
  logic              Rst_n, Stall, Flush, id_valid;
  logic [31:0]       id_pc4, id_rs_data, id_rt_data, id_imm;
  logic [4:0]        id_rs, id_rt, id_rd;
  logic [CTRL_W-1:0] id_ctrl;
  logic              ex_valid, hazard_stall;
  logic [31:0]       ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]        ex_rs, ex_rt, ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CNT_W-1:0]  bubble_cnt;

  id_ex_pipe_reg #(.CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Flush(Flush),
    .id_valid(id_valid), .id_pc4(id_pc4), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_ctrl(id_ctrl),
    .ex_valid(ex_valid), .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .hazard_stall(hazard_stall),
    .bubble_cnt(bubble_cnt)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Reference model of what EX should hold, plus the bubble count as a plain int.
  idex_t m;
  int    m_cnt;

  localparam logic [CTRL_W-1:0] LW_CTRL  = CTRL_W'((1 << REG_WRITE) | (1 << MEM_READ) |
                                                   (1 << MEM_TO_REG) | (1 << ALU_SRC));
  localparam logic [CTRL_W-1:0] ADD_CTRL = CTRL_W'((1 << REG_WRITE) | (1 << REG_DST) |
                                                   (2 << ALU_OP));

  typedef struct {
    logic              v;
    logic [31:0]       imm;
    logic [4:0]        rd;
    logic [CTRL_W-1:0] ctrl;
    logic              exp_v;
    logic [CTRL_W-1:0] exp_ctrl;
    logic [31:0]       exp_imm;
    logic [4:0]        exp_rd;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_hazard();
    return HAZ_EN && (id_valid === 1'b1) && m.valid && m.ctrl[MEM_READ] && (m.rt != 5'd0) &&
           ((m.rt == id_rs) || (m.rt == id_rt)) && (Flush !== 1'b1);
  endfunction

  function automatic void model_update(input bit haz);
    if (!Rst_n) begin
      m     = '0;
      m_cnt = 0;
    end else if (Flush || (!Stall && haz)) begin
      m     = '0;
      m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
    end else if (!Stall) begin
      m.valid   = id_valid;
      m.pc4     = id_pc4;
      m.rs_data = id_rs_data;
      m.rt_data = id_rt_data;
      m.imm     = id_imm;
      m.rs      = id_rs;
      m.rt      = id_rt;
      m.rd      = id_rd;
      m.ctrl    = id_valid ? id_ctrl : '0;
    end
  endfunction

  task automatic compare_all();
    check("ex_valid",   64'(ex_valid),   64'(m.valid));
    check("ex_pc4",     64'(ex_pc4),     64'(m.pc4));
    check("ex_rs_data", 64'(ex_rs_data), 64'(m.rs_data));
    check("ex_rt_data", 64'(ex_rt_data), 64'(m.rt_data));
    check("ex_imm",     64'(ex_imm),     64'(m.imm));
    check("ex_rs",      64'(ex_rs),      64'(m.rs));
    check("ex_rt",      64'(ex_rt),      64'(m.rt));
    check("ex_rd",      64'(ex_rd),      64'(m.rd));
    check("ex_ctrl",    64'(ex_ctrl),    64'(m.ctrl));
    check("bubble_cnt", 64'(bubble_cnt), 64'(m_cnt));
  endtask

  // Inputs are set while Clk is low; the combinational hazard is checked before
  // the edge and the registered outputs on the following falling edge.
  task automatic step(input bit chk);
    bit exp_h;
    exp_h = model_hazard();
    #1;
    if (chk && Rst_n) check("hazard_stall", 64'(hazard_stall), 64'(exp_h));
    @(posedge Clk);
    model_update(exp_h);
    @(negedge Clk);
    if (chk) compare_all();
  endtask

  task automatic rand_id();
    id_valid   = 1'b1;
    id_pc4     = $urandom;
    id_rs_data = $urandom;
    id_rt_data = $urandom;
    id_imm     = $urandom;
    id_rs      = 5'($urandom);
    id_rt      = 5'($urandom);
    id_rd      = 5'($urandom);
    id_ctrl    = CTRL_W'($urandom);
  endtask

  task automatic set_lw(input logic [4:0] rt);
    rand_id();
    id_rs   = 5'd3;
    id_rt   = rt;
    id_ctrl = LW_CTRL;
  endtask

  task automatic set_add();
    rand_id();
    id_rs   = 5'd8;
    id_rt   = 5'd9;
    id_rd   = 5'd10;
    id_ctrl = ADD_CTRL;
  endtask

  initial begin
    int c0;
    logic [31:0] saved_imm;
    logic [4:0]  saved_rd;

    vecs[0] = '{1'b1, 32'hFFFF_8000, 5'd5,  ADD_CTRL,       1'b1, ADD_CTRL,      32'hFFFF_8000, 5'd5};
    vecs[1] = '{1'b0, 32'h1234_5678, 5'd7,  10'h3FF,        1'b0, 10'h000,       32'h1234_5678, 5'd7};
    vecs[2] = '{1'b1, 32'h0000_0000, 5'd31, 10'h3FF,        1'b1, 10'h3FF,       32'h0000_0000, 5'd31};
    vecs[3] = '{1'b1, 32'h0000_7FFF, 5'd0,  LW_CTRL,        1'b1, LW_CTRL,       32'h0000_7FFF, 5'd0};
    vecs[4] = '{1'b0, 32'hDEAD_BEEF, 5'd1,  10'h200,        1'b0, 10'h000,       32'hDEAD_BEEF, 5'd1};

    m = '0;
    m_cnt = 0;

    // Reset with random traffic, including Stall and Flush which must not matter.
    Rst_n = 1'b0; Stall = 1'b0; Flush = 1'b0;
    rand_id();
    step(1'b0);
    rand_id(); Stall = 1'b1; Flush = 1'b1;
    step(1'b1);
    check("reset ex_valid",   64'(ex_valid),   64'd0);
    check("reset ex_ctrl",    64'(ex_ctrl),    64'd0);
    check("reset ex_imm",     64'(ex_imm),     64'd0);
    check("reset bubble_cnt", 64'(bubble_cnt), 64'd0);

    Rst_n = 1'b1; Stall = 1'b0; Flush = 1'b0;
    rand_id();
    saved_imm = id_imm;
    saved_rd  = id_rd;
    step(1'b1);
    check("release ex_imm", 64'(ex_imm), 64'(saved_imm));
    check("release ex_rd",  64'(ex_rd),  64'(saved_rd));

    // Vector table; id_rt = 0 keeps EX free of load-use dependencies.
    for (int i = 0; i < 5; i++) begin
      rand_id();
      id_valid = vecs[i].v;
      id_imm   = vecs[i].imm;
      id_rd    = vecs[i].rd;
      id_ctrl  = vecs[i].ctrl;
      id_rt    = 5'd0;
      step(1'b1);
      check($sformatf("vec%0d ex_valid", i), 64'(ex_valid), 64'(vecs[i].exp_v));
      check($sformatf("vec%0d ex_ctrl", i),  64'(ex_ctrl),  64'(vecs[i].exp_ctrl));
      check($sformatf("vec%0d ex_imm", i),   64'(ex_imm),   64'(vecs[i].exp_imm));
      check($sformatf("vec%0d ex_rd", i),    64'(ex_rd),    64'(vecs[i].exp_rd));
    end

    // Load-use: lw $8 in EX, add reading $8 in ID.
    set_lw(5'd8);
    step(1'b1);
    c0 = m_cnt;
    set_add();
    #1;
    check("lu hazard_stall", 64'(hazard_stall), 64'(HAZ_EN));
    step(1'b1);
    check("lu bubble valid", 64'(ex_valid),   64'(!HAZ_EN));
    check("lu bubble cnt",   64'(bubble_cnt), 64'(c0 + int'(HAZ_EN)));
    step(1'b1);
    check("lu add reaches ex_rs", 64'(ex_rs),   64'd8);
    check("lu add reaches ctrl",  64'(ex_ctrl), 64'(ADD_CTRL));

    // Same pair with the load targeting $zero: never a hazard.
    set_lw(5'd0);
    step(1'b1);
    c0 = m_cnt;
    set_add();
    id_rs = 5'd0;
    #1;
    check("lu zero hazard_stall", 64'(hazard_stall), 64'd0);
    step(1'b1);
    check("lu zero ex_valid", 64'(ex_valid),   64'd1);
    check("lu zero cnt",      64'(bubble_cnt), 64'(c0));

    // Flush together with a hazard: flush wins, upstream not frozen.
    set_lw(5'd8);
    step(1'b1);
    c0 = m_cnt;
    set_add();
    Flush = 1'b1;
    #1;
    check("flush hazard_stall", 64'(hazard_stall), 64'd0);
    step(1'b1);
    check("flush ex_valid", 64'(ex_valid),   64'd0);
    check("flush cnt",      64'(bubble_cnt), 64'(c0 + 1));
    Flush = 1'b0;

    // Stall together with a hazard: EX keeps the lw, no bubble counted.
    set_lw(5'd8);
    step(1'b1);
    c0 = m_cnt;
    set_add();
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      check("stall keeps lw", 64'(ex_ctrl),    64'(LW_CTRL));
      check("stall cnt",      64'(bubble_cnt), 64'(c0));
    end
    Stall = 1'b0;
    step(1'b1);
    check("post-stall valid", 64'(ex_valid),   64'(!HAZ_EN));
    check("post-stall cnt",   64'(bubble_cnt), 64'(c0 + int'(HAZ_EN)));
    step(1'b1);
    check("post-stall add", 64'(ex_ctrl), 64'(ADD_CTRL));

    // Randomized traffic with small register numbers to provoke dependencies.
    for (int i = 0; i < 400; i++) begin
      rand_id();
      id_valid = ($urandom_range(0, 7) != 0);
      id_rs    = 5'($urandom_range(0, 3));
      id_rt    = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) id_ctrl[MEM_READ] = 1'b1;
      Stall = ($urandom_range(0, 7) == 0);
      Flush = ($urandom_range(0, 9) == 0);
      Rst_n = ($urandom_range(0, 49) != 0);
      step(1'b1);
    end
    Rst_n = 1'b1; Stall = 1'b0;

    // Saturation: flush up to one below all-ones, then across the boundary.
    Flush = 1'b1;
    while (m_cnt < CNT_MAX - 1) step(1'b0);
    check("sat FFFE", 64'(bubble_cnt), 64'h0000_FFFE);
    step(1'b1);
    check("sat FFFF", 64'(bubble_cnt), 64'h0000_FFFF);
    for (int i = 0; i < 2; i++) begin
      step(1'b1);
      check("sat hold", 64'(bubble_cnt), 64'h0000_FFFF);
    end

    // Reset mid-sequence overrides Stall and Flush.
    Stall = 1'b1; Flush = 1'b1; Rst_n = 1'b0;
    rand_id();
    step(1'b1);
    check("mid reset cnt",   64'(bubble_cnt), 64'd0);
    check("mid reset valid", 64'(ex_valid),   64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
